// File: rtl/mini_mips_proc.sv
// Single-cycle word-addressed MIPS-style core with unified 512x32 instruction/data memory.
// Define MINI_MIPS_DEBUG_EN to expose halted, dbg_pc and dbg_reg (r[a[4:0]]) outputs.
module mini_mips_proc (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        exec
`ifdef MINI_MIPS_DEBUG_EN
    ,
    output logic        halted,
    output logic [8:0]  dbg_pc,
    output logic [31:0] dbg_reg
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd1;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BGE   = 6'd50;
    localparam logic [5:0] OP_BLT   = 6'd51;
    localparam logic [5:0] OP_BLE   = 6'd52;

    localparam logic [5:0] FN_ADDU = 6'd0;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLT  = 6'd42;

    logic [31:0] mem [0:511];
    logic [31:0] r   [0:31];

    logic [8:0]  pc_reg, pc_next;
    logic        halted_reg, halt_next;

    logic [31:0] instr;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, rs_val, rt_val;
    logic [8:0]  ea, br_target;
    logic [31:0] lw_data;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mem_we;
    logic        run;

    assign instr     = mem[pc_reg];
    assign op        = instr[31:26];
    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign funct     = instr[5:0];
    assign simm      = {{16{instr[15]}}, instr[15:0]};
    assign rs_val    = (rs == 5'd0) ? 32'd0 : r[rs];
    assign rt_val    = (rt == 5'd0) ? 32'd0 : r[rt];
    // Effective address and branch target only need the low 9 bits (mod 512).
    assign ea        = rs_val[8:0] + instr[8:0];
    assign br_target = pc_reg + 9'd1 + instr[8:0];
    assign lw_data   = mem[ea];
    assign run       = exec && !halted_reg;

    always_comb begin
        pc_next   = pc_reg + 9'd1;
        halt_next = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = 32'd0;
        mem_we    = 1'b0;
        if (instr == 32'd0) begin
            halt_next = 1'b1;
            pc_next   = pc_reg;
        end else begin
            case (op)
                OP_RTYPE: begin
                    rf_waddr = rd;
                    case (funct)
                        FN_ADDU, FN_ADD: begin rf_we = 1'b1; rf_wdata = rs_val + rt_val; end
                        FN_SUB:          begin rf_we = 1'b1; rf_wdata = rs_val - rt_val; end
                        FN_AND:          begin rf_we = 1'b1; rf_wdata = rs_val & rt_val; end
                        FN_OR:           begin rf_we = 1'b1; rf_wdata = rs_val | rt_val; end
                        FN_SLT: begin
                            rf_we    = 1'b1;
                            rf_wdata = {31'd0, ($signed(rs_val) < $signed(rt_val))};
                        end
                        default: ;
                    endcase
                end
                OP_ADDI: begin rf_we = 1'b1; rf_wdata = rs_val + simm; end
                OP_LW:   begin rf_we = 1'b1; rf_wdata = lw_data; end
                OP_SW:   mem_we = 1'b1;
                OP_J:    pc_next = instr[8:0];
                OP_BGE:  if ($signed(rs_val) >= $signed(rt_val)) pc_next = br_target;
                OP_BLT:  if ($signed(rs_val) <  $signed(rt_val)) pc_next = br_target;
                OP_BLE:  if ($signed(rs_val) <= $signed(rt_val)) pc_next = br_target;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg     <= 9'd0;
            halted_reg <= 1'b0;
            for (int i = 0; i < 32; i++) r[i] <= 32'd0;
        end else if (run) begin
            pc_reg     <= pc_next;
            halted_reg <= halt_next;
            if (rf_we && rf_waddr != 5'd0) r[rf_waddr] <= rf_wdata;
        end
    end

    // Memory is never reset; execution owns the write port whenever exec is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (exec) begin
                if (!halted_reg && mem_we) mem[ea] <= rt_val;
            end else if (we) begin
                mem[a] <= d;
            end
        end
    end

`ifdef MINI_MIPS_DEBUG_EN
    assign halted  = halted_reg;
    assign dbg_pc  = pc_reg;
    assign dbg_reg = (a[4:0] == 5'd0) ? 32'd0 : r[a[4:0]];
`endif

endmodule

// File: tb/tb_mini_mips_proc.sv
// Directed bench for mini_mips_proc: single-step vector table plus multi-cycle program sequences.
module tb_mini_mips_proc;

    logic        clk = 1'b0;
    logic        rst, we, exec;
    logic [8:0]  a;
    logic [31:0] d;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mini_mips_proc dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .d    (d),
        .we   (we),
        .exec (exec)
    );

    typedef struct {
        logic [31:0] instr;
        logic        is_mem;
        logic [8:0]  idx;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [17];
    logic [31:0] sort_prog [38];
    logic [31:0] br_prog [14];

    function automatic logic [31:0] ei(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] er(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    endfunction

    function automatic logic [31:0] ej(input int tgt);
        return {6'd1, 17'd0, tgt[8:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    task automatic load_word(input logic [8:0] addr, input logic [31:0] data);
        exec = 1'b0;
        we   = 1'b1;
        a    = addr;
        d    = data;
        tick();
        we   = 1'b0;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        exec = 1'b0;
        we   = 1'b0;
        tick();
        rst  = 1'b0;
    endtask

    task automatic run_until_halt(input string name, input int max_cycles);
        exec = 1'b1;
        for (int i = 0; i < max_cycles && !dut.halted_reg; i++) tick();
        exec = 1'b0;
        check(name, {31'd0, dut.halted_reg}, 32'd1);
    endtask

    task automatic check_sort(input string tag);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] want;
            want = (k == 0) ? 32'd3 : (k == 1) ? 32'd5 : (k == 2) ? 32'd7 : 32'd9;
            check($sformatf("%s_mem%0d", tag, 41 + k), dut.mem[41 + k], want);
            check($sformatf("%s_r%0d", tag, 19 + k), dut.r[19 + k], want);
        end
        check({tag, "_pc"}, {23'd0, dut.pc_reg}, 32'd37);
    endtask

    initial begin
        // Single-step vectors: each is loaded at the current pc and retired alone.
        tbl[0]  = '{ei(35, 0, 1, 100),  1'b0, 9'd1,   32'h7FFF_FFFF};
        tbl[1]  = '{ei(8, 1, 2, 1),     1'b0, 9'd2,   32'h8000_0000};
        tbl[2]  = '{ei(8, 0, 0, 5),     1'b0, 9'd0,   32'h0000_0000};
        tbl[3]  = '{er(2, 1, 3, 42),    1'b0, 9'd3,   32'h0000_0001};
        tbl[4]  = '{er(1, 2, 4, 42),    1'b0, 9'd4,   32'h0000_0000};
        tbl[5]  = '{er(1, 2, 5, 36),    1'b0, 9'd5,   32'h0000_0000};
        tbl[6]  = '{er(1, 2, 6, 37),    1'b0, 9'd6,   32'hFFFF_FFFF};
        tbl[7]  = '{er(0, 1, 7, 34),    1'b0, 9'd7,   32'h8000_0001};
        tbl[8]  = '{er(1, 1, 8, 0),     1'b0, 9'd8,   32'hFFFF_FFFE};
        tbl[9]  = '{er(2, 2, 9, 32),    1'b0, 9'd9,   32'h0000_0000};
        tbl[10] = '{er(1, 1, 0, 32),    1'b0, 9'd0,   32'h0000_0000};
        tbl[11] = '{ei(8, 0, 10, 2),    1'b0, 9'd10,  32'h0000_0002};
        tbl[12] = '{ei(43, 0, 1, 101),  1'b1, 9'd101, 32'h7FFF_FFFF};
        tbl[13] = '{ei(35, 0, 11, 101), 1'b0, 9'd11,  32'h7FFF_FFFF};
        tbl[14] = '{ei(8, 6, 12, -3),   1'b0, 9'd12,  32'hFFFF_FFFC};
        tbl[15] = '{er(1, 2, 3, 63),    1'b0, 9'd3,   32'h0000_0001};
        tbl[16] = '{ei(63, 1, 3, 4660), 1'b0, 9'd3,   32'h0000_0001};

        for (int k = 0; k < 38; k++) sort_prog[k] = er(0, 0, 0, 63);
        sort_prog[0]  = ei(8, 14, 14, 41);
        sort_prog[1]  = ei(8, 0, 3, 5);
        sort_prog[2]  = ei(43, 14, 3, 0);
        sort_prog[3]  = ei(8, 0, 3, 9);
        sort_prog[4]  = ei(43, 14, 3, 1);
        sort_prog[5]  = ei(8, 0, 3, 3);
        sort_prog[6]  = ei(43, 14, 3, 2);
        sort_prog[7]  = ei(8, 0, 3, 7);
        sort_prog[8]  = ei(43, 14, 3, 3);
        sort_prog[9]  = ei(8, 0, 1, 4);
        sort_prog[10] = ei(8, 0, 2, 1);
        sort_prog[11] = ei(50, 2, 1, 21);
        sort_prog[12] = er(14, 2, 8, 32);
        sort_prog[13] = ei(35, 8, 5, 0);
        sort_prog[14] = ei(8, 2, 6, -1);
        sort_prog[16] = ei(51, 6, 0, 10);
        sort_prog[17] = er(14, 6, 9, 32);
        sort_prog[18] = ei(35, 9, 7, 0);
        sort_prog[20] = ei(52, 7, 5, 6);
        sort_prog[21] = ei(43, 9, 7, 1);
        sort_prog[22] = ei(8, 6, 6, -1);
        sort_prog[23] = ej(16);
        sort_prog[27] = er(14, 6, 9, 32);
        sort_prog[28] = ei(43, 9, 5, 1);
        sort_prog[29] = ei(8, 2, 2, 1);
        sort_prog[30] = ej(11);
        sort_prog[33] = ei(35, 14, 19, 0);
        sort_prog[34] = ei(35, 14, 20, 1);
        sort_prog[35] = ei(35, 14, 21, 2);
        sort_prog[36] = ei(35, 14, 22, 3);
        sort_prog[37] = 32'd0;

        br_prog[0]  = ei(8, 0, 1, 3);
        br_prog[1]  = ei(8, 0, 2, 3);
        br_prog[2]  = ei(50, 1, 2, 1);
        br_prog[3]  = ei(8, 0, 10, 1);
        br_prog[4]  = ei(8, 0, 6, -1);
        br_prog[5]  = ei(51, 6, 0, 1);
        br_prog[6]  = ei(8, 0, 11, 1);
        br_prog[7]  = ei(52, 1, 2, 1);
        br_prog[8]  = ei(8, 0, 12, 1);
        br_prog[9]  = ei(51, 1, 2, 1);
        br_prog[10] = ei(8, 0, 15, 9);
        br_prog[11] = ej(13);
        br_prog[12] = ei(8, 0, 13, 1);
        br_prog[13] = 32'd0;

        // Reset held for 5 cycles.
        rst = 1'b1; exec = 1'b0; we = 1'b0; a = '0; d = '0;
        repeat (5) tick();
        rst = 1'b0;
        check("rst_pc", {23'd0, dut.pc_reg}, 32'd0);
        check("rst_halted", {31'd0, dut.halted_reg}, 32'd0);
        check("rst_r8", dut.r[8], 32'd0);

        // Give memory a known content; rst never clears it.
        for (int k = 0; k < 512; k++) load_word(k[8:0], 32'd0);

        load_word(9'd0, 32'h2108_000A);
        load_word(9'd1, 32'd0);
        exec = 1'b1;
        tick();
        tick();
        check("load_r8", dut.r[8], 32'd10);
        check("load_halted", {31'd0, dut.halted_reg}, 32'd1);
        check("load_pc", {23'd0, dut.pc_reg}, 32'd1);
        tick();
        check("halt_sticky_pc", {23'd0, dut.pc_reg}, 32'd1);
        check("halt_sticky", {31'd0, dut.halted_reg}, 32'd1);
        exec = 1'b0;

        // Loader must be ignored while exec is high and during a reset edge.
        load_word(9'd5, 32'h1111_1111);
        exec = 1'b1; we = 1'b1; a = 9'd5; d = 32'hDEAD_BEEF;
        tick();
        exec = 1'b0; we = 1'b0;
        check("gate_exec_mem5", dut.mem[5], 32'h1111_1111);
        rst = 1'b1; we = 1'b1; a = 9'd6; d = 32'hCAFE_F00D;
        tick();
        rst = 1'b0; we = 1'b0;
        check("gate_rst_mem6", dut.mem[6], 32'd0);

        // Single-step table.
        load_word(9'd100, 32'h7FFF_FFFF);
        do_reset();
        for (int i = 0; i < 17; i++) begin
            load_word(i[8:0], tbl[i].instr);
            exec = 1'b1;
            tick();
            exec = 1'b0;
            if (tbl[i].is_mem)
                check($sformatf("vec%0d_mem%0d", i, tbl[i].idx), dut.mem[tbl[i].idx], tbl[i].exp);
            else
                check($sformatf("vec%0d_r%0d", i, tbl[i].idx), dut.r[tbl[i].idx[4:0]], tbl[i].exp);
            check($sformatf("vec%0d_pc", i), {23'd0, dut.pc_reg}, i + 1);
        end

        // Branch boundaries and jump.
        for (int k = 0; k < 14; k++) load_word(k[8:0], br_prog[k]);
        do_reset();
        run_until_halt("br_halt", 100);
        check("br_bge_eq_taken", dut.r[10], 32'd0);
        check("br_blt_neg_taken", dut.r[11], 32'd0);
        check("br_ble_eq_taken", dut.r[12], 32'd0);
        check("br_j_skip", dut.r[13], 32'd0);
        check("br_blt_not_taken", dut.r[15], 32'd9);
        check("br_pc", {23'd0, dut.pc_reg}, 32'd13);

        // Offset -1 branches onto itself forever.
        load_word(9'd0, ei(50, 0, 0, -1));
        do_reset();
        exec = 1'b1;
        repeat (5) tick();
        exec = 1'b0;
        check("self_loop_pc", {23'd0, dut.pc_reg}, 32'd0);
        check("self_loop_halted", {31'd0, dut.halted_reg}, 32'd0);

        // Insertion sort.
        for (int k = 0; k < 38; k++) load_word(k[8:0], sort_prog[k]);
        do_reset();
        run_until_halt("sort_halt", 2000);
        check_sort("sort");

        // Same sort with a 3-cycle pause after 40 instructions (pc is 18 there).
        do_reset();
        exec = 1'b1;
        repeat (40) tick();
        exec = 1'b0;
        check("pause_pc_at_40", {23'd0, dut.pc_reg}, 32'd18);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("pause_hold%0d_pc", k), {23'd0, dut.pc_reg}, 32'd18);
        end
        run_until_halt("pause_halt", 2000);
        check_sort("pause");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
